// File: rtl/tpm_spi_pkg.sv
// Shared definitions for the TPM SPI frame tracker.
// Contents: frame FSM state type, header geometry, flow-control bit positions and
// the data-phase size limit.
package tpm_spi_pkg;

    typedef enum logic [1:0] {
        StHeader,
        StWait,
        StData,
        StDone
    } frame_state_e;

    localparam int unsigned HDR_BITS     = 32;
    // Header edge (1-based) at which the flow-control bit is driven
    localparam int unsigned FLOW_BIT_IDX = 31;
    // In-byte edge (1-based) of a wait byte at which the flow-control bit is driven
    localparam int unsigned WAIT_FLOW_E  = 7;
    localparam int unsigned MAX_XFER     = 64;
    localparam int unsigned CNT_W        = $clog2(MAX_XFER + 1);

    // Header field bit positions
    localparam int unsigned HDR_DIR_BIT  = 31;
    localparam int unsigned HDR_RSVD_BIT = 30;
    localparam int unsigned HDR_SIZE_MSB = 29;
    localparam int unsigned HDR_SIZE_LSB = 24;

endpackage

// File: rtl/sync_ff.sv
// Level synchronizer: Depth-flop chain with asynchronous active-low reset to 0.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset
//   d_i    - asynchronous level input
//   q_o    - synchronized level (output of the last stage)
module sync_ff #(
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Depth-1:0] sync_q;
    logic [Depth-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[Depth-2:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[Depth-1];

endmodule

// File: rtl/tpm_spi_frame_tracker.sv
// TPM SPI frame tracker in the SPI_clock domain.
// Decodes the 4-byte TPM SPI header from MOSI, drives wait-state flow control onto
// the MISO flow bit until the transaction handler is ready, then counts data bytes
// and flags host overrun.
// Ports:
//   SPI_clock, reset_n      - SPI clock (rising edge), async active-low reset
//   SPI_cs_n                - chip select; high asynchronously clears frame state
//   SPI_mosi                - host data, MSB first
//   xfer_ready              - handler readiness level (foreign clock domain)
//   flow_en, flow_val       - MISO override enable and flow bit (1 = ready)
//   hdr_valid/read/size/addr- decoded header; fields survive CS deassertion
//   data_phase, byte_strobe - data-phase level and per-byte pulse
//   data_cnt, frame_done    - completed data bytes, all bytes done
//   overrun                 - sticky: host clocked past the end of the frame
module tpm_spi_frame_tracker
    import tpm_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 24
) (
    input  logic              SPI_clock,
    input  logic              reset_n,
    input  logic              SPI_cs_n,
    input  logic              SPI_mosi,
    input  logic              xfer_ready,
    output logic              flow_en,
    output logic              flow_val,
    output logic              hdr_valid,
    output logic              hdr_read,
    output logic [6:0]        hdr_size,
    output logic [ADDR_W-1:0] hdr_addr,
    output logic              data_phase,
    output logic              byte_strobe,
    output logic [6:0]        data_cnt,
    output logic              frame_done,
    output logic              overrun
);

    localparam int unsigned BIT_CNT_W = $clog2(HDR_BITS);
    localparam logic [BIT_CNT_W-1:0] FLOW_CNT = BIT_CNT_W'(FLOW_BIT_IDX - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_CNT = BIT_CNT_W'(HDR_BITS - 1);
    localparam logic [2:0] WAIT_FLOW_CNT = 3'(WAIT_FLOW_E - 1);
    localparam logic [2:0] BYTE_LAST_CNT = 3'd7;

    logic ready_sync;

    sync_ff #(
        .Depth (SYNC_STAGES)
    ) u_ready_sync (
        .clk_i  (SPI_clock),
        .rst_ni (reset_n),
        .d_i    (xfer_ready),
        .q_o    (ready_sync)
    );

    // Frame state is held cleared while CS is high, independent of the clock.
    logic frame_rst_n;
    assign frame_rst_n = reset_n & ~SPI_cs_n;

    frame_state_e            state_q, state_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [HDR_BITS-2:0]     hdr_sr_q, hdr_sr_d;
    logic                    flow_en_q, flow_en_d;
    logic                    flow_val_q, flow_val_d;
    logic                    hdr_valid_q, hdr_valid_d;
    logic                    data_phase_q, data_phase_d;
    logic                    byte_strobe_q, byte_strobe_d;
    logic [CNT_W-1:0]        data_cnt_q, data_cnt_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overrun_q, overrun_d;
    logic                    hdr_read_q, hdr_read_d;
    logic [CNT_W-1:0]        hdr_size_q, hdr_size_d;
    logic [ADDR_W-1:0]       hdr_addr_q, hdr_addr_d;

    // Full header word as seen on the final header edge
    logic [HDR_BITS-1:0] hdr_word;
    logic                unused_rsvd;
    assign hdr_word    = {hdr_sr_q, SPI_mosi};
    assign unused_rsvd = hdr_word[HDR_RSVD_BIT];

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        hdr_sr_d      = hdr_sr_q;
        flow_en_d     = flow_en_q;
        flow_val_d    = flow_val_q;
        hdr_valid_d   = hdr_valid_q;
        data_phase_d  = data_phase_q;
        byte_strobe_d = 1'b0;
        data_cnt_d    = data_cnt_q;
        frame_done_d  = frame_done_q;
        overrun_d     = overrun_q;
        hdr_read_d    = hdr_read_q;
        hdr_size_d    = hdr_size_q;
        hdr_addr_d    = hdr_addr_q;

        unique case (state_q)
            StHeader: begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                hdr_sr_d  = {hdr_sr_q[HDR_BITS-3:0], SPI_mosi};
                if (bit_cnt_q == FLOW_CNT) begin
                    flow_en_d  = 1'b1;
                    flow_val_d = ready_sync;
                end
                if (bit_cnt_q == LAST_CNT) begin
                    // bit_cnt wraps to 0 here, so its low bits become the in-byte counter
                    hdr_read_d  = hdr_word[HDR_DIR_BIT];
                    hdr_size_d  = {1'b0, hdr_word[HDR_SIZE_MSB:HDR_SIZE_LSB]} + CNT_W'(1);
                    hdr_addr_d  = hdr_word[ADDR_W-1:0];
                    hdr_valid_d = 1'b1;
                    flow_en_d   = 1'b0;
                    if (flow_val_q) begin
                        state_d      = StData;
                        data_phase_d = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                if (bit_cnt_q[2:0] == WAIT_FLOW_CNT) begin
                    flow_en_d  = 1'b1;
                    flow_val_d = ready_sync;
                end
                if (bit_cnt_q[2:0] == BYTE_LAST_CNT) begin
                    flow_en_d = 1'b0;
                    if (flow_val_q) begin
                        state_d      = StData;
                        data_phase_d = 1'b1;
                    end
                end
            end
            StData: begin
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                if (bit_cnt_q[2:0] == BYTE_LAST_CNT) begin
                    data_cnt_d    = data_cnt_q + CNT_W'(1);
                    byte_strobe_d = 1'b1;
                    if (data_cnt_d == hdr_size_q) begin
                        state_d      = StDone;
                        frame_done_d = 1'b1;
                        data_phase_d = 1'b0;
                    end
                end
            end
            StDone: begin
                overrun_d = 1'b1;
            end
            default: begin
                state_d = StHeader;
            end
        endcase
    end

    always_ff @(posedge SPI_clock or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state_q       <= StHeader;
            bit_cnt_q     <= '0;
            hdr_sr_q      <= '0;
            flow_en_q     <= 1'b0;
            flow_val_q    <= 1'b0;
            hdr_valid_q   <= 1'b0;
            data_phase_q  <= 1'b0;
            byte_strobe_q <= 1'b0;
            data_cnt_q    <= '0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            hdr_sr_q      <= hdr_sr_d;
            flow_en_q     <= flow_en_d;
            flow_val_q    <= flow_val_d;
            hdr_valid_q   <= hdr_valid_d;
            data_phase_q  <= data_phase_d;
            byte_strobe_q <= byte_strobe_d;
            data_cnt_q    <= data_cnt_d;
            frame_done_q  <= frame_done_d;
            overrun_q     <= overrun_d;
        end
    end

    // Header fields are only cleared by reset_n so the clock50 side can still
    // capture them after CS deasserts.
    always_ff @(posedge SPI_clock or negedge reset_n) begin
        if (!reset_n) begin
            hdr_read_q <= 1'b0;
            hdr_size_q <= '0;
            hdr_addr_q <= '0;
        end else begin
            hdr_read_q <= hdr_read_d;
            hdr_size_q <= hdr_size_d;
            hdr_addr_q <= hdr_addr_d;
        end
    end

    assign flow_en     = flow_en_q;
    assign flow_val    = flow_val_q;
    assign hdr_valid   = hdr_valid_q;
    assign hdr_read    = hdr_read_q;
    assign hdr_size    = hdr_size_q;
    assign hdr_addr    = hdr_addr_q;
    assign data_phase  = data_phase_q;
    assign byte_strobe = byte_strobe_q;
    assign data_cnt    = data_cnt_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_tpm_spi_frame_tracker.sv
// Directed bench for tpm_spi_frame_tracker: header decode, wait states, data
// counting, overrun, CS abort and mid-frame reset.
module tb_tpm_spi_frame_tracker;

    logic        SPI_clock;
    logic        reset_n;
    logic        SPI_cs_n;
    logic        SPI_mosi;
    logic        xfer_ready;
    logic        flow_en;
    logic        flow_val;
    logic        hdr_valid;
    logic        hdr_read;
    logic [6:0]  hdr_size;
    logic [23:0] hdr_addr;
    logic        data_phase;
    logic        byte_strobe;
    logic [6:0]  data_cnt;
    logic        frame_done;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;

    tpm_spi_frame_tracker #(
        .SYNC_STAGES (2),
        .ADDR_W      (24)
    ) dut (
        .SPI_clock   (SPI_clock),
        .reset_n     (reset_n),
        .SPI_cs_n    (SPI_cs_n),
        .SPI_mosi    (SPI_mosi),
        .xfer_ready  (xfer_ready),
        .flow_en     (flow_en),
        .flow_val    (flow_val),
        .hdr_valid   (hdr_valid),
        .hdr_read    (hdr_read),
        .hdr_size    (hdr_size),
        .hdr_addr    (hdr_addr),
        .data_phase  (data_phase),
        .byte_strobe (byte_strobe),
        .data_cnt    (data_cnt),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    // One SPI clock: drive MOSI in the low phase, rise, fall. Returns at the
    // falling edge, half a period away from the sampling edge.
    task automatic clk_edge(input logic mosi);
        SPI_mosi = mosi;
        #5 SPI_clock = 1'b1;
        #5 SPI_clock = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) clk_edge(w[31-i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) clk_edge(b[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clk_edge(1'b0);
    endtask

    task automatic test_reset();
        SPI_clock  = 1'b0;
        reset_n    = 1'b0;
        SPI_cs_n   = 1'b1;
        SPI_mosi   = 1'b0;
        xfer_ready = 1'b0;
        #3;
        n_vec++; if ({flow_en, flow_val, hdr_valid, hdr_read} !== 4'b0000) begin
            n_err++; $display("FAIL rst_flags: got %b exp 0000",
                              {flow_en, flow_val, hdr_valid, hdr_read}); end
        n_vec++; if (hdr_size !== 7'd0) begin
            n_err++; $display("FAIL rst_size: got %0d exp 0", hdr_size); end
        n_vec++; if (hdr_addr !== 24'h0) begin
            n_err++; $display("FAIL rst_addr: got %h exp 000000", hdr_addr); end
        n_vec++; if ({data_phase, byte_strobe, frame_done, overrun} !== 4'b0000) begin
            n_err++; $display("FAIL rst_levels: got %b exp 0000",
                              {data_phase, byte_strobe, frame_done, overrun}); end
        n_vec++; if (data_cnt !== 7'd0) begin
            n_err++; $display("FAIL rst_cnt: got %0d exp 0", data_cnt); end
        #4 reset_n = 1'b1;
        #3;
    endtask

    // Read of 4 bytes at 0xD40018 with the handler already ready: no wait state.
    task automatic test_read4();
        int strobes;
        xfer_ready = 1'b1;
        idle(4);
        SPI_cs_n = 1'b0;
        send_bits(32'h83D40018, 31);
        n_vec++; if ({flow_en, flow_val} !== 2'b11) begin
            n_err++; $display("FAIL rd4_flow31: got %b exp 11", {flow_en, flow_val}); end
        n_vec++; if (hdr_valid !== 1'b0) begin
            n_err++; $display("FAIL rd4_valid31: got %b exp 0", hdr_valid); end
        clk_edge(1'b0);
        n_vec++; if ({hdr_valid, hdr_read, flow_en} !== 3'b110) begin
            n_err++; $display("FAIL rd4_hdr_flags: got %b exp 110",
                              {hdr_valid, hdr_read, flow_en}); end
        n_vec++; if (hdr_size !== 7'd4) begin
            n_err++; $display("FAIL rd4_size: got %0d exp 4", hdr_size); end
        n_vec++; if (hdr_addr !== 24'hD40018) begin
            n_err++; $display("FAIL rd4_addr: got %h exp d40018", hdr_addr); end
        n_vec++; if (data_phase !== 1'b1) begin
            n_err++; $display("FAIL rd4_dphase: got %b exp 1", data_phase); end
        strobes = 0;
        for (int i = 0; i < 32; i++) begin
            clk_edge(i[0]);
            if (byte_strobe === 1'b1) strobes++;
            if (i == 30) begin
                n_vec++; if ({frame_done, data_phase} !== 2'b01) begin
                    n_err++; $display("FAIL rd4_edge63: got %b exp 01",
                                      {frame_done, data_phase}); end
            end
        end
        n_vec++; if (strobes !== 4) begin
            n_err++; $display("FAIL rd4_strobes: got %0d exp 4", strobes); end
        n_vec++; if (data_cnt !== 7'd4) begin
            n_err++; $display("FAIL rd4_cnt: got %0d exp 4", data_cnt); end
        n_vec++; if ({frame_done, data_phase, overrun} !== 3'b100) begin
            n_err++; $display("FAIL rd4_done: got %b exp 100",
                              {frame_done, data_phase, overrun}); end
    endtask

    // Write of 1 byte; handler becomes ready during the second wait byte.
    task automatic test_wait_write();
        SPI_cs_n   = 1'b1;
        xfer_ready = 1'b0;
        idle(4);
        SPI_cs_n = 1'b0;
        n_vec++; if ({hdr_valid, overrun, frame_done} !== 3'b000) begin
            n_err++; $display("FAIL wr_cs_clear: got %b exp 000",
                              {hdr_valid, overrun, frame_done}); end
        send_bits(32'h00D40024, 31);
        n_vec++; if ({flow_en, flow_val} !== 2'b10) begin
            n_err++; $display("FAIL wr_flow31: got %b exp 10", {flow_en, flow_val}); end
        clk_edge(1'b0);
        n_vec++; if ({hdr_valid, hdr_read, flow_en, data_phase} !== 4'b1000) begin
            n_err++; $display("FAIL wr_hdr_flags: got %b exp 1000",
                              {hdr_valid, hdr_read, flow_en, data_phase}); end
        n_vec++; if (hdr_size !== 7'd1) begin
            n_err++; $display("FAIL wr_size: got %0d exp 1", hdr_size); end
        n_vec++; if (hdr_addr !== 24'hD40024) begin
            n_err++; $display("FAIL wr_addr: got %h exp d40024", hdr_addr); end
        for (int e = 1; e <= 8; e++) begin
            clk_edge(1'b1);
            if (e == 7) begin
                n_vec++; if ({flow_en, flow_val} !== 2'b10) begin
                    n_err++; $display("FAIL wr_wait1_e7: got %b exp 10",
                                      {flow_en, flow_val}); end
            end
        end
        n_vec++; if ({flow_en, data_phase} !== 2'b00) begin
            n_err++; $display("FAIL wr_wait1_e8: got %b exp 00", {flow_en, data_phase}); end
        clk_edge(1'b1);
        xfer_ready = 1'b1;
        for (int e = 2; e <= 8; e++) begin
            clk_edge(1'b1);
            if (e == 7) begin
                n_vec++; if ({flow_en, flow_val} !== 2'b11) begin
                    n_err++; $display("FAIL wr_wait2_e7: got %b exp 11",
                                      {flow_en, flow_val}); end
            end
        end
        n_vec++; if ({flow_en, data_phase} !== 2'b01) begin
            n_err++; $display("FAIL wr_wait2_e8: got %b exp 01", {flow_en, data_phase}); end
        send_byte(8'hA5);
        n_vec++; if (data_cnt !== 7'd1) begin
            n_err++; $display("FAIL wr_cnt: got %0d exp 1", data_cnt); end
        n_vec++; if ({frame_done, byte_strobe, data_phase} !== 3'b110) begin
            n_err++; $display("FAIL wr_done: got %b exp 110",
                              {frame_done, byte_strobe, data_phase}); end
    endtask

    // Maximum-size read, then extra clocks past the end of the frame.
    task automatic test_size64_overrun();
        SPI_cs_n = 1'b1;
        idle(2);
        SPI_cs_n = 1'b0;
        send_bits(32'hBF001234, 32);
        n_vec++; if (hdr_size !== 7'd64) begin
            n_err++; $display("FAIL s64_size: got %0d exp 64", hdr_size); end
        n_vec++; if ({hdr_read, data_phase} !== 2'b11) begin
            n_err++; $display("FAIL s64_flags: got %b exp 11", {hdr_read, data_phase}); end
        n_vec++; if (hdr_addr !== 24'h001234) begin
            n_err++; $display("FAIL s64_addr: got %h exp 001234", hdr_addr); end
        for (int b = 0; b < 64; b++) begin
            send_byte(8'(b));
            n_vec++; if (data_cnt !== 7'(b + 1)) begin
                n_err++; $display("FAIL s64_cnt: byte %0d got %0d exp %0d",
                                  b, data_cnt, b + 1); end
            n_vec++; if (frame_done !== (b == 63)) begin
                n_err++; $display("FAIL s64_done: byte %0d got %b exp %b",
                                  b, frame_done, (b == 63)); end
        end
        n_vec++; if (overrun !== 1'b0) begin
            n_err++; $display("FAIL s64_no_ovr: got %b exp 0", overrun); end
        clk_edge(1'b1);
        n_vec++; if (overrun !== 1'b1) begin
            n_err++; $display("FAIL s64_ovr1: got %b exp 1", overrun); end
        idle(7);
        n_vec++; if ({overrun, frame_done, byte_strobe} !== 3'b110) begin
            n_err++; $display("FAIL s64_ovr8: got %b exp 110",
                              {overrun, frame_done, byte_strobe}); end
        n_vec++; if (data_cnt !== 7'd64) begin
            n_err++; $display("FAIL s64_sat: got %0d exp 64", data_cnt); end
    endtask

    // CS abort mid-header; header fields of the last frame must survive.
    task automatic test_cs_abort();
        SPI_cs_n = 1'b1;
        #2;
        n_vec++; if ({overrun, frame_done, hdr_valid} !== 3'b000) begin
            n_err++; $display("FAIL cs_async_clr: got %b exp 000",
                              {overrun, frame_done, hdr_valid}); end
        n_vec++; if (data_cnt !== 7'd0) begin
            n_err++; $display("FAIL cs_cnt_clr: got %0d exp 0", data_cnt); end
        SPI_cs_n = 1'b0;
        send_bits(32'h0A55AA33, 13);
        SPI_cs_n = 1'b1;
        #2;
        n_vec++; if ({hdr_valid, flow_en, flow_val, data_phase} !== 4'b0000) begin
            n_err++; $display("FAIL cs_abort_lv: got %b exp 0000",
                              {hdr_valid, flow_en, flow_val, data_phase}); end
        n_vec++; if ({hdr_read, hdr_size, hdr_addr} !== {1'b1, 7'd64, 24'h001234}) begin
            n_err++; $display("FAIL cs_hold_hdr: got %b/%0d/%h exp 1/64/001234",
                              hdr_read, hdr_size, hdr_addr); end
        idle(1);
        SPI_cs_n = 1'b0;
        // Reserved bit 30 set; must not leak into size or direction
        send_bits(32'h41ABCDEF, 32);
        n_vec++; if ({hdr_valid, hdr_read, data_phase} !== 3'b101) begin
            n_err++; $display("FAIL cs_next_flags: got %b exp 101",
                              {hdr_valid, hdr_read, data_phase}); end
        n_vec++; if (hdr_size !== 7'd2) begin
            n_err++; $display("FAIL cs_next_size: got %0d exp 2", hdr_size); end
        n_vec++; if (hdr_addr !== 24'hABCDEF) begin
            n_err++; $display("FAIL cs_next_addr: got %h exp abcdef", hdr_addr); end
    endtask

    // reset_n pulsed in the middle of the second data byte of the previous frame.
    task automatic test_reset_mid_data();
        send_byte(8'h5A);
        n_vec++; if ({data_cnt, frame_done} !== {7'd1, 1'b0}) begin
            n_err++; $display("FAIL rmd_pre: got %0d/%b exp 1/0", data_cnt, frame_done); end
        send_bits(32'hE0000000, 3);
        reset_n = 1'b0;
        #1;
        n_vec++; if ({hdr_read, hdr_size, hdr_addr} !== 32'h0) begin
            n_err++; $display("FAIL rmd_hdr: got %b/%0d/%h exp 0/0/000000",
                              hdr_read, hdr_size, hdr_addr); end
        n_vec++; if ({hdr_valid, data_phase, flow_en, flow_val} !== 4'b0000) begin
            n_err++; $display("FAIL rmd_levels: got %b exp 0000",
                              {hdr_valid, data_phase, flow_en, flow_val}); end
        n_vec++; if (data_cnt !== 7'd0) begin
            n_err++; $display("FAIL rmd_cnt: got %0d exp 0", data_cnt); end
        #2 reset_n = 1'b1;
        SPI_cs_n = 1'b1;
        idle(3);
        SPI_cs_n = 1'b0;
        send_bits(32'hC2000001, 31);
        n_vec++; if ({flow_en, flow_val} !== 2'b11) begin
            n_err++; $display("FAIL rmd_flow31: got %b exp 11", {flow_en, flow_val}); end
        clk_edge(1'b1);
        n_vec++; if ({hdr_valid, hdr_read, hdr_size, hdr_addr} !==
                     {1'b1, 1'b1, 7'd3, 24'h000001}) begin
            n_err++; $display("FAIL rmd_next: got %b/%b/%0d/%h exp 1/1/3/000001",
                              hdr_valid, hdr_read, hdr_size, hdr_addr); end
        SPI_cs_n = 1'b1;
        #2;
    endtask

    initial begin
        test_reset();
        test_read4();
        test_wait_write();
        test_size64_overrun();
        test_cs_abort();
        test_reset_mid_data();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tpm_spi_frame_tracker.md
# tpm_spi_frame_tracker

SPI_clock-domain frame tracker for TPM SPI transactions, sitting beside the SPI_SLAVE serializer on the host-facing edge of the I/O module. It samples MOSI to decode the 4-byte TPM SPI header (direction, transfer size, 24-bit address). It generates TPM wait-state flow control by overriding MISO on the flow-control bit until the transaction handler signals readiness. It then counts data-phase bytes, so downstream logic knows frame position and detects host overrun.

## Interface

- SYNC_STAGES, 2: synchronizer depth for `xfer_ready` into SPI_clock domain (≥2).
- ADDR_W, 24: header address width; fixed by protocol, not to be changed.

- SPI_clock  input  1  SPI serial clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- SPI_cs_n  input  1  chip select, active-low; high asynchronously clears frame state.
- SPI_mosi  input  1  host data, sampled on SPI_clock rising edge, MSB first.
- xfer_ready  input  1  level from transaction handler (clock50 domain): 1 = data phase may start.
- flow_en  output  1  1 = MISO mux must drive `flow_val` instead of the serializer bit.
- flow_val  output  1  flow-control bit value: 1 = ready, 0 = wait.
- hdr_valid  output  1  level; header fully received this frame.
- hdr_read  output  1  header bit 7; 1 = read, 0 = write.
- hdr_size  output  7  transfer size in bytes, 1..64.
- hdr_addr  output  ADDR_W  header bytes 1-3, MSB first.
- data_phase  output  1  level; in data phase.
- byte_strobe  output  1  one SPI_clock cycle pulse per completed data byte.
- data_cnt  output  7  data bytes completed this frame, 0..64.
- frame_done  output  1  level; data_cnt == hdr_size.
- overrun  output  1  sticky; host clocked past frame_done.

## Operation

- States: HEADER, WAIT, DATA, DONE. After reset and while SPI_cs_n high: HEADER, bit_cnt=0.
- HEADER: shift MOSI into 32-bit header register; bit_cnt increments per edge (k = 1..32).
  - Edge 31: register `flow_en`=1 and `flow_val`=synced `xfer_ready`.
  - Edge 32:
    - Latch hdr_read = bit 31, hdr_size = bits[29:24]+1, hdr_addr = bits[23:0].
    - Set hdr_valid=1 and clear flow_en.
    - Next state DATA if flow_val=1, else WAIT.
  - Header bit 30 is ignored (reserved).
- WAIT: host clocks wait bytes; MOSI ignored. 3-bit in-byte counter e = 1..8.
  - Edge e=7: flow_en=1, flow_val=synced ready.
  - Edge e=8: flow_en=0; go to DATA if flow_val=1, else stay in WAIT.
  - No wait-byte limit.
- DATA:
  - data_phase=1.
  - At each e=8: data_cnt+1, byte_strobe=1 for that cycle.
  - When data_cnt reaches hdr_size: go to DONE, frame_done=1, data_phase=0.
- DONE: any further rising edge sets overrun=1. Overrun stays set until CS deasserts.
- xfer_ready sampled only through the SYNC_STAGES flop chain, clocked by SPI_clock, reset by reset_n to 0. The chain is not cleared by CS.
- SPI_cs_n high (async, any state, mid-byte included):
  - Clears state to HEADER and zeroes bit counters, data_cnt, flow_en, flow_val, hdr_valid, data_phase, byte_strobe, frame_done and overrun.
  - hdr_read/hdr_size/hdr_addr hold their last values for clock50-side capture.
- reset_n low: everything above cleared, plus hdr_read=0, hdr_size=0, hdr_addr=0, sync chain=0.
- Counters never wrap: data_cnt saturates at hdr_size. The in-byte counter wraps 7→0 by design.

## Timing

- Every output is a flop on SPI_clock rising edge; no combinational paths input→output.
- flow_val/flow_en are updated at edge 31 (or e=7). They are valid through the following SPI_clock low phase, before the serializer's MISO falling-edge launch for bit 32 (or e=8).
- hdr_valid rises at edge 32; byte_strobe rises at e=8 of each data byte and falls at the next edge.
- Ready latency: xfer_ready rise → earliest flow_val=1 at the first flow-bit edge after SYNC_STAGES SPI_clock edges.
- xfer_ready dropping during DATA has no effect; the frame proceeds.
- Consumers in clock50 sample hdr_valid/frame_done/overrun as levels through their own synchronizers.

## Structure

- Shared package `tpm_spi_pkg`:
  - State enum (HEADER/WAIT/DATA/DONE).
  - HDR_BITS=32, FLOW_BIT_IDX=31, WAIT_FLOW_E=7, MAX_XFER=64, header field bit positions.
- One sub-module: `sync_ff` (parameterized-depth level synchronizer with async active-low reset) for xfer_ready. Reused elsewhere in the I/O module.

## Test plan

- Header 0x83_D4_00_18, xfer_ready=1 long before CS:
  - flow_val=1 at edge 31.
  - hdr_read=1, hdr_size=4, hdr_addr=0xD40018, hdr_valid=1 at edge 32.
  - DATA: 4 byte_strobes, frame_done at edge 64.
- Header 0x00_D4_00_24 (write, size 1), xfer_ready=0, raised during the 2nd wait byte:
  - flow_val=0 at edge 31 and on wait byte 1.
  - flow_val=1 on the first wait byte after sync latency; DATA follows; data_cnt=1, frame_done=1.
- Size 64 read: data_cnt counts 1..64, frame_done at byte 64; 8 extra clocks → overrun=1, data_cnt stays 64.
- CS deasserted after edge 13: state HEADER, all levels 0, hdr fields unchanged. The next full header decodes correctly.
- reset_n pulsed low mid-DATA: all outputs zero immediately, including hdr_addr=0. The next frame decodes normally.
